// File: rtl/spram_bus_ctrl.sv
// ============================================================================
// Module   : spram_bus_ctrl
// Purpose  : Bus-side initiator for a single-port SRAM macro wrapper. Accepts
//            req/gnt transactions, issues them combinationally to the SRAM
//            port and returns one in-order response per granted transaction
//            through a 2-entry response buffer with credit-based grant.
// Options  : SPRAM_CTRL_ZEROIZE_EN - when defined, INIT zero-fills the whole
//            SRAM (one word per cycle) before traffic is accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_bus_ctrl #(
   parameter  int DEPTH   = 1024,
   parameter  int WIDTH   = 32,
   localparam int DEPTH_W = $clog2(DEPTH),
   localparam int BE_W    = WIDTH / 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               req,
   input  logic               we,
   input  logic [BE_W-1:0]    be,
   input  logic [DEPTH_W-1:0] addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic               gnt,
   output logic               rvalid,
   input  logic               rready,
   output logic [WIDTH-1:0]   rdata,
   output logic               init_done,
   output logic               SRAM_CE,
   output logic               SRAM_WE,
   output logic [WIDTH-1:0]   SRAM_BWM,
   output logic [WIDTH-1:0]   SRAM_D,
   output logic [DEPTH_W-1:0] SRAM_A,
   input  logic [WIDTH-1:0]   SRAM_Q
);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic               handshake;
   logic               pop;
   logic               push;
   logic [WIDTH-1:0]   push_data;
   logic [2:0]         credit;
   logic [WIDTH-1:0]   bwm_bus;

   // Issue stage: one transaction is in flight between SRAM issue and buffer push
   logic               inflight;
   logic               is_read;

   // Response buffer: two entries, circular pointers, occupancy 0..2
   logic [WIDTH-1:0]   resp_mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;

   // Byte enables widened to a per-bit write mask for the SRAM
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bwm
         assign bwm_bus[gi] = be[gi/8];
      end
   endgenerate

   assign rvalid    = (count != 2'd0);
   assign rdata     = resp_mem[rd_ptr];
   assign pop       = rvalid && rready;
   assign push      = inflight;
   assign push_data = is_read ? SRAM_Q : '0;

   // Credit: buffered + in-flight responses, less the one leaving this cycle,
   // must leave room for the response of a new grant.
   assign credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign gnt       = (state == RUN) && (credit < 3'd2);
   assign handshake = req && gnt;
   assign init_done = (state == RUN);

`ifdef SPRAM_CTRL_ZEROIZE_EN
   localparam logic [DEPTH_W-1:0] LAST_ADDR = DEPTH_W'(DEPTH - 1);

   logic [DEPTH_W-1:0] zero_cnt;

   // Zero-fill address counter, advances once per INIT cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         zero_cnt <= '0;
      end else if (state == INIT) begin
         zero_cnt <= zero_cnt + DEPTH_W'(1);
      end
   end
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: INIT leaves after one cycle, or after the last zero-fill write
   always_comb begin
      state_nxt = state;
      case (state)
         INIT: begin
`ifdef SPRAM_CTRL_ZEROIZE_EN
            if (zero_cnt == LAST_ADDR) begin
               state_nxt = RUN;
            end
`else
            state_nxt = RUN;
`endif
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // SRAM port drive: bus pass-through in RUN, zero-fill writes in INIT
   always_comb begin
      SRAM_CE  = 1'b0;
      SRAM_WE  = 1'b0;
      SRAM_BWM = '0;
      SRAM_D   = '0;
      SRAM_A   = '0;
      if (state == RUN) begin
         SRAM_CE  = handshake;
         SRAM_WE  = we;
         SRAM_BWM = bwm_bus;
         SRAM_D   = wdata;
         SRAM_A   = addr;
      end
`ifdef SPRAM_CTRL_ZEROIZE_EN
      // Gated by RST_N so the port stays idle while reset is held; the first
      // fill write happens in the very first cycle after release.
      else if (RST_N) begin
         SRAM_CE  = 1'b1;
         SRAM_WE  = 1'b1;
         SRAM_BWM = '1;
         SRAM_D   = '0;
         SRAM_A   = zero_cnt;
      end
`endif
   end

   // Issue-stage tracking: remembers a handshake until its SRAM data returns
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         inflight <= 1'b0;
         is_read  <= 1'b0;
      end else begin
         inflight <= handshake;
         if (handshake) begin
            is_read <= !we;
         end
      end
   end

   // Response FIFO: push the cycle after a handshake, pop on rvalid && rready
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         resp_mem[0] <= '0;
         resp_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            resp_mem[wr_ptr] <= push_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/spram_bus_ctrl.md
Name: spram_bus_ctrl

Overview:
- Bus-side initiator for the single-port SRAM macro wrapper (`CLK`/`CE`/`WE`/`BWM`/`D`/`A`/`Q` port set).
- Accepts req/gnt memory transactions from a core or DMA, drives the SRAM port and returns exactly one in-order response per granted transaction.
- Contains a 2-entry response buffer with `rready` backpressure and credit-based grant.
- Sits between the interconnect and each instruction/data SRAM instance.

Parameters:
- DEPTH, 1024, SRAM word count; must match the attached SRAM.
- WIDTH, 32, data width in bits; multiple of 8.
- DEPTH_W, $clog2(DEPTH), local: address width.
- BE_W, WIDTH/8, local: byte-enable width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req  in  1  transaction request.
- we  in  1  1=write, 0=read; sampled with req.
- be  in  BE_W  byte enables, write only.
- addr  in  DEPTH_W  word address.
- wdata  in  WIDTH  write data.
- gnt  out  1  request accepted this cycle (req && gnt = handshake).
- rvalid  out  1  response available at buffer head.
- rready  in  1  consumer accepts response.
- rdata  out  WIDTH  read data; 0 for write responses.
- init_done  out  1  controller ready for traffic.
- SRAM_CE  out  1  to SRAM CE.
- SRAM_WE  out  1  to SRAM WE.
- SRAM_BWM  out  WIDTH  to SRAM BWM; bit i = be[i/8].
- SRAM_D  out  WIDTH  to SRAM D.
- SRAM_A  out  DEPTH_W  to SRAM A.
- SRAM_Q  in  WIDTH  from SRAM Q; valid the cycle after a read issue.

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, rdata=0, init_done=0.
  - SRAM_CE=0, SRAM_WE=0, SRAM_BWM=0, SRAM_D=0, SRAM_A=0.
  - Buffer count=0, inflight=0, state=INIT.
- States:
  - INIT: macro-dependent, see Optional Feature.
  - RUN: normal operation; INIT→RUN sets init_done=1. RUN has no exit except reset.
- SRAM issue path is combinational from the bus:
  - SRAM_CE = req && gnt.
  - SRAM_WE = we.
  - SRAM_A = addr.
  - SRAM_D = wdata.
  - SRAM_BWM = expanded be.
  - When not issuing, SRAM_CE=0 and the data/address outputs are don't-care. The bench checks only when CE=1.
- Issue-stage register: inflight (1 bit) plus is_read, set on each handshake; cleared next cycle unless a new handshake occurs.
- Buffer push: in the cycle after a handshake, push one entry: SRAM_Q if is_read, else 0.
- Response buffer: 2-entry FIFO.
  - rvalid = count != 0; rdata = head entry.
  - pop = rvalid && rready.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- Credit / grant: gnt = (state==RUN) && (count + inflight − pop < 2).
  - gnt may depend on req (combinational). gnt must not depend on rdata.
- Latency:
  - Read granted in cycle N: SRAM read at edge N, buffered at edge N+1, rvalid=1 from cycle N+2.
  - Sustained throughput is 1 transaction/cycle with rready held at 1.
- Ordering: responses return strictly in grant order; reads and writes are never reordered.
- Write-then-read to the same addr in consecutive cycles returns the new data; the SRAM serialises this naturally.
- be=0 write: CE/WE still pulse with BWM=0, memory is unchanged, and a response is still returned.
- Buffer full (count=2) with rready=0: gnt=0; no SRAM access and no data loss.
- Reset mid-operation: in-flight and buffered responses are discarded; state returns to INIT.

Optional Feature:
- Macro: SPRAM_CTRL_ZEROIZE_EN.
- Defined:
  - INIT walks a DEPTH_W-bit counter 0..DEPTH-1, one write per cycle: SRAM_CE=1, SRAM_WE=1, SRAM_BWM=all ones, SRAM_D=0, SRAM_A=counter.
  - gnt=0 throughout; no responses are generated.
  - After the write to DEPTH-1: go to RUN; init_done=1 the next cycle, exactly DEPTH+1 cycles after RST_N deassertion.
- Undefined:
  - INIT lasts one cycle with no SRAM access; init_done=1 on the second cycle after reset release.
  - No counter logic.

Test Plan:
- Reset/init: release RST_N; without macro, init_done=1 at cycle 2. With macro, 1024 zero writes to A=0..1023, then init_done=1 at cycle 1025; a later read of 0x3FF returns 0.
- Basic R/W: write addr=5, wdata=0xDEADBEEF, be=0xF, then read addr=5 → one write response with rdata=0, then read response 0xDEADBEEF arriving 2 cycles after its grant.
- Byte masking: preload addr=7 with 0x11223344, write be=0x5 wdata=0xAABBCCDD → read returns 0x11BB33DD.
- Backpressure: rready=0, issue 4 back-to-back reads → exactly 2 grants, gnt then 0. Raise rready → the remaining 2 are granted, and all 4 responses return in order with correct data.
- Streaming: rready=1, 100 alternating write/read pairs to random addresses → gnt continuously 1, every read matches the preceding write.
- Reset mid-traffic: assert RST_N low with count=2 → rvalid=0 immediately; after release no stale response appears.
